systolic_array_controller: RTL and testbench

- Sequences an N x N weight-stationary systolic array of 8-bit processing elements.
- On start: loads all PE weights row by row, then streams activation vectors into the left edge with per-row skew, then drains the array.
- Issues per-column result strobes at the bottom edge; raises done.
- Sits between the host/buffer logic (start, weight/activation memories) and the PE grid.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/skew_buffer.sv | 32 +++
 rtl/systolic_array_controller.sv | 175 +++++++++++++++++
 tb/tb_systolic_array_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared controller state encoding and PE timing constants.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } ctrl_state_t;

  // Every PE operation is a strobe cycle followed by an execute cycle.
  localparam int PE_STEP_CYCLES = 2;
  localparam int DATA_W         = 8;

endpackage

// File: rtl/skew_buffer.sv
// skew_buffer: triangular delay line feeding the array's left edge.
// Row i is delayed by i steps; row 0 passes straight through.
module skew_buffer #(
  parameter int N      = 2,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       shift_en,
  input  logic [N-1:0][DATA_W-1:0]   din,
  output logic [N-1:0][DATA_W-1:0]   dout
);

  assign dout[0] = din[0];

  for (genvar i = 1; i < N; i++) begin : g_row
    logic [i-1:0][DATA_W-1:0] sr;

    // Advance this row's delay line once per step boundary.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sr <= '0;
      end else if (shift_en) begin
        sr[0] <= din[i];
        for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
      end
    end

    assign dout[i] = sr[i-1];
  end

endmodule

// File: rtl/systolic_array_controller.sv
// systolic_array_controller: sequences weight load, skewed activation
// streaming and drain for an N x N weight-stationary array.
// Optional macro SYSTOLIC_CTRL_WEIGHT_REUSE_EN adds reuse_weights, which lets
// a job skip the weight load once any job has completed since reset.
module systolic_array_controller
  import systolic_pkg::*;
#(
  parameter  int N        = 2,
  parameter  int MAX_VECS = 16,
  parameter  int AW       = $clog2(MAX_VECS),
  localparam int WAW      = (N > 1) ? $clog2(N) : 1,
  localparam int RW       = $clog2(N) + 1,
  localparam int SW       = AW + $clog2(2*N) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [AW:0]           num_vecs,
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
  input  logic                  reuse_weights,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [WAW-1:0]        w_addr,
  output logic                  w_rd,
  input  logic [N*DATA_W-1:0]   w_rdata,
  output logic [AW-1:0]         a_addr,
  output logic                  a_rd,
  input  logic [N*DATA_W-1:0]   a_rdata,
  output logic [N-1:0]          pe_load_weight,
  output logic [N*DATA_W-1:0]   pe_weight,
  output logic                  pe_valid,
  output logic [N*DATA_W-1:0]   pe_a_in,
  output logic [N-1:0]          out_valid
);

  ctrl_state_t              state, nxt;
  logic [1:0]               cyc;       // cycle within a row (LOAD_W) or step phase (bit 0)
  logic [RW-1:0]            row;
  logic [SW-1:0]            step;
  logic [AW:0]              nvec;
  logic [AW:0]              nvec_in;
  logic [N*DATA_W-1:0]      w_hold;
  logic [N-1:0][DATA_W-1:0] a_reg;
  logic [N-1:0][DATA_W-1:0] skew_out;
  logic [N-1:0]             ov_hit, exec_mask;
  logic                     reuse_ok;
  logic                     streaming;

  assign nvec_in   = (num_vecs > (AW+1)'(MAX_VECS)) ? (AW+1)'(MAX_VECS) : num_vecs;
  assign streaming = (state == COMPUTE) || (state == DRAIN);

`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
  logic have_w;
  assign reuse_ok = reuse_weights && have_w;

  // Remember that the array holds weights from a completed job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           have_w <= 1'b0;
    else if (state == DONE) have_w <= 1'b1;
  end
`else
  assign reuse_ok = 1'b0;
`endif

  // Next state and per-cycle strobes.
  always_comb begin
    nxt            = state;
    busy           = 1'b0;
    done           = 1'b0;
    w_rd           = 1'b0;
    a_rd           = 1'b0;
    pe_valid       = 1'b0;
    pe_load_weight = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!reuse_ok)          nxt = LOAD_W;
          else if (nvec_in == '0) nxt = DONE;
          else                    nxt = COMPUTE;
        end
      end
      LOAD_W: begin
        busy = 1'b1;
        w_rd = (cyc == 2'd0);
        if (cyc == 2'd1) pe_load_weight[row[WAW-1:0]] = 1'b1;
        if (cyc == 2'd3 && row == RW'(N-1)) nxt = (nvec == '0) ? DONE : COMPUTE;
      end
      COMPUTE: begin
        busy     = 1'b1;
        a_rd     = !cyc[0];
        pe_valid = cyc[0];
        if (cyc[0] && step == SW'(nvec) - SW'(1)) nxt = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        pe_valid = cyc[0];
        if (cyc[0] && step == SW'(nvec) + SW'(2*N-2)) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Column j's bottom PE finishes vector (step - (N-1) - j) on this step.
  always_comb begin
    ov_hit = '0;
    for (int j = 0; j < N; j++)
      ov_hit[j] = (step >= SW'(N-1+j)) && (step < SW'(N-1+j) + SW'(nvec));
  end

  // State, counters and data holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cyc       <= '0;
      row       <= '0;
      step      <= '0;
      nvec      <= '0;
      w_hold    <= '0;
      a_reg     <= '0;
      exec_mask <= '0;
      out_valid <= '0;
    end else begin
      state     <= nxt;
      // Result is in the bottom PE one cycle after the execute cycle.
      exec_mask <= pe_valid ? ov_hit : '0;
      out_valid <= exec_mask;
      unique case (state)
        IDLE: begin
          cyc  <= '0;
          row  <= '0;
          step <= '0;
          if (start) nvec <= nvec_in;
        end
        LOAD_W: begin
          cyc <= cyc + 2'd1;
          if (cyc == 2'd1) w_hold <= w_rdata;
          if (cyc == 2'd3) row <= row + RW'(1);
        end
        COMPUTE, DRAIN: begin
          cyc <= {1'b0, ~cyc[0]};
          if (cyc[0]) begin
            step  <= step + SW'(1);
            a_reg <= (state == COMPUTE) ? a_rdata : '0;
          end
        end
        default: begin
          cyc  <= '0;
          row  <= '0;
          step <= '0;
        end
      endcase
    end
  end

  // Fetched row is presented on the read-data cycle and then held for the step.
  assign pe_weight = (state == LOAD_W && cyc == 2'd1) ? w_rdata : w_hold;
  assign w_addr    = (state == LOAD_W)  ? row[WAW-1:0] : '0;
  assign a_addr    = (state == COMPUTE) ? step[AW-1:0] : '0;

  skew_buffer #(.N(N), .DATA_W(DATA_W)) u_skew (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (streaming && cyc[0]),
    .din      (a_reg),
    .dout     (skew_out)
  );

  assign pe_a_in = skew_out;

endmodule

// File: tb/tb_systolic_array_controller.sv
// tb_systolic_array_controller: directed bench with a behavioural PE grid.
module tb_systolic_array_controller;
  localparam int N    = 2;
  localparam int MAXV = 16;
  localparam int AW   = 4;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [AW:0] num_vecs = '0;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
  logic reuse_weights = 1'b0;
`endif
  logic busy, done, w_rd, a_rd, pe_valid;
  logic [0:0]      w_addr;
  logic [AW-1:0]   a_addr;
  logic [N*8-1:0]  w_rdata = '0, a_rdata = '0, pe_weight, pe_a_in;
  logic [N-1:0]    pe_load_weight, out_valid;
  logic [N*8-1:0]  wmem [N];
  logic [N*8-1:0]  amem [MAXV];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  systolic_array_controller #(.N(N), .MAX_VECS(MAXV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_vecs(num_vecs),
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    .reuse_weights(reuse_weights),
`endif
    .busy(busy), .done(done), .w_addr(w_addr), .w_rd(w_rd), .w_rdata(w_rdata),
    .a_addr(a_addr), .a_rd(a_rd), .a_rdata(a_rdata),
    .pe_load_weight(pe_load_weight), .pe_weight(pe_weight), .pe_valid(pe_valid),
    .pe_a_in(pe_a_in), .out_valid(out_valid)
  );

  // One-cycle-latency buffer memories
  always @(posedge clk) begin
    if (w_rd) w_rdata <= wmem[w_addr];
    if (a_rd) a_rdata <= amem[a_addr];
  end

  // Monitor + behavioural weight-stationary grid (cumulative logs)
  int cyc_n = 0, pv_cnt = 0, wrd_cnt = 0, lw_cnt = 0, done_cnt = 0, ard_cnt = 0;
  int st_cyc = 0, done_cyc = 0;
  int ov_cnt [N] = '{default:0};
  int res    [N][256];
  int ov_cyc [N][256];
  int a_log [256], a_cyc [256], lw_val [64], lw_cyc [64];
  int mw [N][N] = '{default:0};
  int mp [N][N] = '{default:0};
  int ma [N][N] = '{default:0};
  int np [N][N], na [N][N];
  logic pv_d = 1'b0;
  logic [N-1:0] lw_d = '0;

  always @(negedge clk) begin
    cyc_n++;
    for (int r = 0; r < N; r++)
      if (lw_d[r]) for (int j = 0; j < N; j++) mw[r][j] = int'(pe_weight[8*j +: 8]);
    if (pv_d) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          na[i][j] = (j == 0) ? int'(pe_a_in[8*i +: 8]) : ma[i][j-1];
          np[i][j] = ((i == 0) ? 0 : mp[i-1][j]) + mw[i][j] * na[i][j];
        end
      ma = na;
      mp = np;
    end
    pv_d = pe_valid;
    lw_d = pe_load_weight;
    if (pe_valid) pv_cnt++;
    if (w_rd) wrd_cnt++;
    if (|pe_load_weight && lw_cnt < 64) begin
      lw_val[lw_cnt] = int'(pe_load_weight); lw_cyc[lw_cnt] = cyc_n; lw_cnt++;
    end
    if (a_rd && ard_cnt < 256) begin
      a_log[ard_cnt] = int'(a_addr); a_cyc[ard_cnt] = cyc_n; ard_cnt++;
    end
    for (int j = 0; j < N; j++)
      if (out_valid[j] && ov_cnt[j] < 256) begin
        res[j][ov_cnt[j]] = mp[N-1][j]; ov_cyc[j][ov_cnt[j]] = cyc_n; ov_cnt[j]++;
      end
    if (done) begin done_cnt++; done_cyc = cyc_n; end
    if (start && !busy && !done) st_cyc = cyc_n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go(input int nv);
    @(posedge clk); #1 start = 1'b1; num_vecs = nv[AW:0];
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 400) begin
      @(negedge clk);
      seen = done;
      k++;
    end
    #1 chk({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  int b_pv, b_wrd, b_lw, b_done, b_ard, b_ov0, b_ov1;
  task automatic snap();
    b_pv = pv_cnt; b_wrd = wrd_cnt; b_lw = lw_cnt; b_done = done_cnt;
    b_ard = ard_cnt; b_ov0 = ov_cnt[0]; b_ov1 = ov_cnt[1];
  endtask

  function automatic int colsum(input int s, input int j);
    logic [N*8-1:0] v, w0, w1;
    v = amem[s]; w0 = wmem[0]; w1 = wmem[1];
    return int'(v[7:0]) * int'(w0[8*j +: 8]) + int'(v[15:8]) * int'(w1[8*j +: 8]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int k;
    wmem[0] = {8'd2, 8'd1};
    wmem[1] = {8'd4, 8'd3};
    for (int s = 0; s < MAXV; s++) amem[s] = '0;
    amem[0] = {8'd1, 8'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk("rst_outputs", 64'({busy, done, w_rd, a_rd, pe_valid, w_addr, a_addr,
                               pe_load_weight, pe_weight, pe_a_in, out_valid}), 64'd0);
    reset_n = 1'b1;

    // Reset in the middle of the weight load (row 1)
    snap();
    go(1);
    found = 1'b0; k = 0;
    while (!found && k < 50) begin @(negedge clk); found = w_rd && (w_addr == 1'b1); k++; end
    chk("midload_reach_row1", 64'(found), 64'd1);
    #1 reset_n = 1'b0;
    #1 chk("midload_outputs", 64'({busy, done, w_rd, a_rd, pe_valid, w_addr, a_addr,
                                   pe_load_weight, pe_weight, pe_a_in, out_valid}), 64'd0);
    repeat (3) @(negedge clk);
    #1 chk("midload_no_done", 64'(done_cnt - b_done), 64'd0);
    reset_n = 1'b1;

    // N=2, weights [[1,2],[3,4]], one vector [1,1]
    snap();
    go(1);
    wait_done("job1");
    chk("job1_lw0", 64'(lw_val[b_lw]), 64'd1);
    chk("job1_lw1", 64'(lw_val[b_lw+1]), 64'd2);
    chk("job1_lw_gap", 64'(lw_cyc[b_lw+1] - lw_cyc[b_lw]), 64'd4);
    chk("job1_pv", 64'(pv_cnt - b_pv), 64'd4);
    chk("job1_ov0_cnt", 64'(ov_cnt[0] - b_ov0), 64'd1);
    chk("job1_ov1_cnt", 64'(ov_cnt[1] - b_ov1), 64'd1);
    chk("job1_ov_gap", 64'(ov_cyc[1][b_ov1] - ov_cyc[0][b_ov0]), 64'd2);
    chk("job1_col0", 64'(res[0][b_ov0]), 64'd4);
    chk("job1_col1", 64'(res[1][b_ov1]), 64'd6);
    chk("job1_busy_after", 64'(busy), 64'd0);

    // Three vectors, hand-computed column sums
    amem[0] = {8'd2, 8'd1}; amem[1] = {8'd0, 8'd3}; amem[2] = {8'd5, 8'd2};
    snap();
    go(3);
    wait_done("job3");
    chk("job3_pv", 64'(pv_cnt - b_pv), 64'd6);
    chk("job3_c0v0", 64'(res[0][b_ov0]),   64'd7);
    chk("job3_c0v1", 64'(res[0][b_ov0+1]), 64'd3);
    chk("job3_c0v2", 64'(res[0][b_ov0+2]), 64'd17);
    chk("job3_c1v0", 64'(res[1][b_ov1]),   64'd10);
    chk("job3_c1v1", 64'(res[1][b_ov1+1]), 64'd6);
    chk("job3_c1v2", 64'(res[1][b_ov1+2]), 64'd24);

    // Zero vectors: load only, done right after LOAD_W
    snap();
    go(0);
    wait_done("job0");
    chk("job0_wrd", 64'(wrd_cnt - b_wrd), 64'd2);
    chk("job0_pv", 64'(pv_cnt - b_pv), 64'd0);
    chk("job0_ov", 64'(ov_cnt[0] - b_ov0 + ov_cnt[1] - b_ov1), 64'd0);
    chk("job0_done_lat", 64'(done_cyc - lw_cyc[lw_cnt-1]), 64'd3);

    // start held high across a whole job
    amem[0] = {8'd1, 8'd1};
    snap();
    @(posedge clk); #1 start = 1'b1; num_vecs = 5'd1;
    wait_done("held1");
    chk("held_wrd_one_job", 64'(wrd_cnt - b_wrd), 64'd2);
    chk("held_done_once", 64'(done_cnt - b_done), 64'd1);
    @(negedge clk); #1 chk("held_idle_gap", 64'(busy), 64'd0);
    @(negedge clk); #1 chk("held_restart", 64'(busy), 64'd1);
    @(posedge clk); #1 start = 1'b0;
    wait_done("held2");
    chk("held_two_jobs", 64'(done_cnt - b_done), 64'd2);

    // Full-depth job
    for (int s = 0; s < MAXV; s++) amem[s] = {8'(s + 1), 8'(2 * s)};
    snap();
    go(16);
    wait_done("job16");
    chk("job16_ard", 64'(ard_cnt - b_ard), 64'd16);
    for (int s = 0; s < MAXV; s++) chk($sformatf("job16_addr%0d", s), 64'(a_log[b_ard+s]), 64'(s));
    chk("job16_pv", 64'(pv_cnt - b_pv), 64'd19);
    chk("job16_ov0", 64'(ov_cnt[0] - b_ov0), 64'd16);
    chk("job16_ov1", 64'(ov_cnt[1] - b_ov1), 64'd16);
    chk("job16_c0_last", 64'(res[0][b_ov0+15]), 64'(colsum(15, 0)));
    chk("job16_c1_v7", 64'(res[1][b_ov1+7]), 64'(colsum(7, 1)));

    // num_vecs above MAX_VECS is clamped
    snap();
    go(20);
    wait_done("job20");
    chk("clamp_ard", 64'(ard_cnt - b_ard), 64'd16);
    chk("clamp_pv", 64'(pv_cnt - b_pv), 64'd19);

`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    // Second job reuses the loaded weights
    amem[0] = {8'd1, 8'd1};
    reuse_weights = 1'b1;
    snap();
    go(1);
    wait_done("reuse");
    reuse_weights = 1'b0;
    chk("reuse_wrd", 64'(wrd_cnt - b_wrd), 64'd0);
    chk("reuse_lw", 64'(lw_cnt - b_lw), 64'd0);
    chk("reuse_compute_lat", 64'(a_cyc[b_ard] - st_cyc), 64'd1);
    chk("reuse_col0", 64'(res[0][b_ov0]), 64'd4);
    chk("reuse_col1", 64'(res[1][b_ov1]), 64'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
